// File: rtl/async_fifo_pkg.sv
// Shared constants and helpers for the asynchronous FIFO blocks (read and write side).
//
// Contents:
//   DefDataWidth / DefBufDepth / DefCntWidth : default parameter values
//   wrap_inc(ptr, depth)                     : pointer increment that wraps at depth
package async_fifo_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefBufDepth  = 3;
  localparam int unsigned DefCntWidth  = 16;

  // Next value of a circular pointer; depth need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 32'd1 >= depth) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/async_fifo_rd_stream_if.sv
// Valid/ready stream bundle produced by the FIFO read-side drain engine.
//
// Signals:
//   m_valid : word available (driven by master)
//   m_ready : sink accepts   (driven by slave)
//   m_data  : stream word    (driven by master)
interface async_fifo_rd_stream_if #(
  parameter int unsigned DataWidth = async_fifo_pkg::DefDataWidth
);

  logic                 m_valid;
  logic                 m_ready;
  logic [DataWidth-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/async_fifo_rd_skid.sv
// Circular buffer of BufDepth words used to absorb the FIFO read latency and stream
// backpressure. The owner guarantees no push when full and no pop when empty.
//
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (contents cleared to 0)
//   push_i        : write wdata_i at tail, advance tail
//   pop_i         : advance head
//   flush_i       : clear head/tail/count; overrides push and pop
//   wdata_i       : word to store
//   count_o       : occupancy 0..BufDepth
//   head_data_o   : word at head
module async_fifo_rd_skid
  import async_fifo_pkg::*;
#(
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned BufDepth  = DefBufDepth,
  localparam int unsigned PtrWidth = $clog2(BufDepth),
  localparam int unsigned CntWidth = $clog2(BufDepth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [CntWidth-1:0]  count_o,
  output logic [DataWidth-1:0] head_data_o
);

  logic [DataWidth-1:0] mem_q [BufDepth];
  logic [DataWidth-1:0] mem_d [BufDepth];
  logic [PtrWidth-1:0]  head_q, head_d;
  logic [PtrWidth-1:0]  tail_q, tail_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      // Stored words stay in memory but become unreachable.
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[tail_q] = wdata_i;
        tail_d        = PtrWidth'(wrap_inc(32'(tail_q), BufDepth));
      end
      if (pop_i) begin
        head_d = PtrWidth'(wrap_inc(32'(head_q), BufDepth));
      end
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + CntWidth'(1);
        2'b01:   cnt_d = cnt_q - CntWidth'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign count_o     = cnt_q;
  assign head_data_o = mem_q[head_q];

endmodule

// File: rtl/async_fifo_rd_stream_sva.sv
// Assertion checker for async_fifo_rd_stream, intended to be bound into the top.
//
// Ports (all inputs): clock/reset, rempty, rinc, buffer occupancy, in-flight flag,
// and the stream signals m_valid/m_ready/m_data.
module async_fifo_rd_stream_sva
  import async_fifo_pkg::*;
#(
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned BufDepth  = DefBufDepth,
  localparam int unsigned CntWidth = $clog2(BufDepth + 1)
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  input logic                 rempty_i,
  input logic                 rinc_i,
  input logic [CntWidth-1:0]  buf_cnt_i,
  input logic                 inflight_i,
  input logic                 m_valid_i,
  input logic                 m_ready_i,
  input logic [DataWidth-1:0] m_data_i
);

  a_no_read_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rinc_i && rempty_i));

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (32'(buf_cnt_i) + 32'(inflight_i)) <= BufDepth);

  // A flush in the following cycle cannot move head before the next edge, so the
  // held word is stable here even across a flush.
  a_data_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (m_valid_i && !m_ready_i) |=> $stable(m_data_i));

endmodule

// File: rtl/async_fifo_rd_stream.sv
// Read-side drain engine for the asynchronous FIFO (read clock domain only).
// Issues rinc whenever the FIFO is non-empty and the buffer has room for the word
// already in flight plus one more, captures rdata one cycle later, and presents the
// buffer head as a valid/ready stream. rinc never depends on m_ready.
//
// Ports:
//   rclk, rrst_n : read clock, asynchronous active-low reset
//   rempty       : FIFO empty flag (registered in the FIFO)
//   rdata        : FIFO read data, valid the cycle after rinc
//   rinc         : FIFO read strobe
//   flush        : synchronous discard of buffered and in-flight words
//   m_if         : stream output (m_valid/m_ready/m_data)
//   rd_count     : words delivered, wrapping
module async_fifo_rd_stream
  import async_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned BUF_DEPTH  = DefBufDepth,
  parameter int unsigned CNT_WIDTH  = DefCntWidth
) (
  input  logic                       rclk,
  input  logic                       rrst_n,
  input  logic                       rempty,
  input  logic [DATA_WIDTH-1:0]      rdata,
  output logic                       rinc,
  input  logic                       flush,
  async_fifo_rd_stream_if.master     m_if,
  output logic [CNT_WIDTH-1:0]       rd_count
);

  localparam int unsigned BufCntWidth = $clog2(BUF_DEPTH + 1);

  logic                   inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]   rd_count_q, rd_count_d;
  logic [BufCntWidth-1:0] buf_cnt;
  logic [DATA_WIDTH-1:0]  head_data;
  logic [DATA_WIDTH-1:0]  m_data;
  logic                   m_valid;
  logic                   m_ready;
  logic                   room;
  logic                   capture;
  logic                   pop;

  assign m_ready = m_if.m_ready;

  always_comb begin
    // Reserve a slot for the word already in flight so the buffer cannot overflow.
    room       = (32'(buf_cnt) + 32'(inflight_q)) < BUF_DEPTH;
    rinc       = rrst_n && !rempty && !flush && room;
    inflight_d = rinc;
    capture    = inflight_q && !flush;
    m_valid    = (buf_cnt != '0) && !flush;
    m_data     = head_data;
    pop        = m_valid && m_ready;
    rd_count_d = rd_count_q + CNT_WIDTH'(pop);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      inflight_q <= 1'b0;
      rd_count_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      rd_count_q <= rd_count_d;
    end
  end

  async_fifo_rd_skid #(
    .DataWidth (DATA_WIDTH),
    .BufDepth  (BUF_DEPTH)
  ) u_skid (
    .clk_i       (rclk),
    .rst_ni      (rrst_n),
    .push_i      (capture),
    .pop_i       (pop),
    .flush_i     (flush),
    .wdata_i     (rdata),
    .count_o     (buf_cnt),
    .head_data_o (head_data)
  );

  assign m_if.m_valid = m_valid;
  assign m_if.m_data  = m_data;
  assign rd_count     = rd_count_q;

endmodule
